// File: rtl/conv_encoder_tx.sv
// conv_encoder_tx
//   Rate-1/2, K=3 convolutional encoder (generators 7 and 5 octal) with
//   frame framing. Each frame carries FRAME_LEN data bits followed by two
//   zero tail bits that return the encoder to the all-zero state.
//
// Parameters
//   FRAME_LEN : data bits per frame (1..65535)
//   ERR_N     : error-burst period exponent (3..8), used only with
//               CONV_ENC_ERRINJ_EN
//
// Build option
//   CONV_ENC_ERRINJ_EN : when defined, d_out[1] is inverted in periodic
//                        bursts over the first 256 symbols after reset,
//                        and err_o flags each corrupted symbol.
//
// Ports
//   clk      : clock, rising edge
//   rst      : synchronous active-high reset
//   enable_i : d_in valid this cycle
//   d_in     : information bit
//   ready_o  : block accepts d_in this cycle (low during the tail)
//   valid_o  : d_out holds a code symbol
//   d_out    : {G=7 output, G=5 output}
//   sof_o    : first symbol of a frame
//   eof_o    : last tail symbol of a frame
//   err_o    : current symbol carries an injected error
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for the first bit of a frame
// DATA  | accepting data bits, gaps allowed
// TAIL  | flushing two zero bits, input ignored
module conv_encoder_tx #(
    parameter int FRAME_LEN = 64,
    parameter int ERR_N     = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable_i,
    input  logic       d_in,
    output logic       ready_o,
    output logic       valid_o,
    output logic [1:0] d_out,
    output logic       sof_o,
    output logic       eof_o,
    output logic       err_o
);

    typedef enum logic [1:0] {IDLE, DATA, TAIL} state_t;

    localparam logic [15:0] LAST_IDX = 16'(FRAME_LEN - 1);

    if (FRAME_LEN < 1 || FRAME_LEN > 65535) begin : g_bad_frame_len
        $error("conv_encoder_tx: FRAME_LEN out of range");
    end
    if (ERR_N < 3 || ERR_N > 8) begin : g_bad_err_n
        $error("conv_encoder_tx: ERR_N out of range");
    end

    state_t      state;
    logic [1:0]  s;
    logic [15:0] bit_cnt;
    logic        tail_last;

    logic        accept;
    logic        fire;
    logic        enc_bit;
    logic        inj;
    logic [1:0]  code;

    assign ready_o = (state != TAIL);
    assign accept  = enable_i && ready_o;
    // A symbol is produced for every accepted bit and for both tail cycles.
    assign fire    = accept || (state == TAIL);
    assign enc_bit = (state == TAIL) ? 1'b0 : d_in;
    assign code    = {enc_bit ^ s[0] ^ s[1], enc_bit ^ s[1]};

`ifdef CONV_ENC_ERRINJ_EN
    // Counts emitted symbols since reset and sticks at 256 so injection
    // stops for good once the first 256 symbols have gone out.
    logic [8:0] sym_cnt;

    assign inj = !sym_cnt[8] && (sym_cnt[ERR_N-1:2] == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            sym_cnt <= '0;
        end else if (fire && !sym_cnt[8]) begin
            sym_cnt <= sym_cnt + 9'd1;
        end
    end
`else
    assign inj   = 1'b0;
    assign err_o = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            s         <= 2'b00;
            bit_cnt   <= '0;
            tail_last <= 1'b0;
            valid_o   <= 1'b0;
            d_out     <= 2'b00;
            sof_o     <= 1'b0;
            eof_o     <= 1'b0;
`ifdef CONV_ENC_ERRINJ_EN
            err_o     <= 1'b0;
`endif
        end else begin
            valid_o <= fire;
            d_out   <= fire ? (code ^ {inj, 1'b0}) : 2'b00;
            sof_o   <= accept && (state == IDLE);
            eof_o   <= (state == TAIL) && tail_last;
`ifdef CONV_ENC_ERRINJ_EN
            err_o   <= fire && inj;
`endif
            if (fire) begin
                s <= {s[0], enc_bit};
            end

            case (state)
                IDLE: begin
                    if (accept) begin
                        bit_cnt   <= 16'd1;
                        tail_last <= 1'b0;
                        state     <= (FRAME_LEN == 1) ? TAIL : DATA;
                    end
                end
                DATA: begin
                    if (accept) begin
                        bit_cnt <= bit_cnt + 16'd1;
                        if (bit_cnt == LAST_IDX) begin
                            state <= TAIL;
                        end
                    end
                end
                TAIL: begin
                    // Two zero shifts leave s at 00 without an explicit clear.
                    if (tail_last) begin
                        state     <= IDLE;
                        bit_cnt   <= '0;
                        tail_last <= 1'b0;
                    end else begin
                        tail_last <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_conv_encoder_tx.sv
// Testbench for conv_encoder_tx. Main instance uses FRAME_LEN = 4; a second
// instance with FRAME_LEN = 1 covers the single-bit frame case. Expected
// symbols come from a generator-polynomial model applied to the whole
// zero-padded frame.
module tb_conv_encoder_tx;

    localparam int FL    = 4;
    localparam int ERR_N = 5;

    typedef bit         bit_q_t[$];
    typedef logic [1:0] sym_q_t[$];

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0, din = 1'b0;
    logic       ready_o, valid_o, sof_o, eof_o, err_o;
    logic [1:0] d_out;
    logic       en1 = 1'b0, din1 = 1'b0;
    logic       ready1, valid1, sof1, eof1, err1;
    logic [1:0] dout1;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    conv_encoder_tx #(.FRAME_LEN(FL), .ERR_N(ERR_N)) dut (
        .clk(clk), .rst(rst), .enable_i(en), .d_in(din),
        .ready_o(ready_o), .valid_o(valid_o), .d_out(d_out),
        .sof_o(sof_o), .eof_o(eof_o), .err_o(err_o)
    );

    conv_encoder_tx #(.FRAME_LEN(1), .ERR_N(ERR_N)) dut1 (
        .clk(clk), .rst(rst), .enable_i(en1), .d_in(din1),
        .ready_o(ready1), .valid_o(valid1), .d_out(dout1),
        .sof_o(sof1), .eof_o(eof1), .err_o(err1)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: records every valid symbol of the main instance.
    logic [1:0] obs_sym[$];
    bit         obs_sof[$], obs_eof[$], obs_err[$];
    int         obs_idx[$], obs_cyc[$];
    int         sym_idx = 0;
    int         idle_bad = 0;
    int         ready_low = 0;
    int         acc_cyc[$];

    always @(negedge clk) begin
        if (valid_o === 1'b1) begin
            obs_sym.push_back(d_out);
            obs_sof.push_back(sof_o);
            obs_eof.push_back(eof_o);
            obs_err.push_back(err_o);
            obs_idx.push_back(sym_idx);
            obs_cyc.push_back(cyc);
            sym_idx++;
        end else if (d_out !== 2'b00 || sof_o !== 1'b0 || eof_o !== 1'b0 || err_o !== 1'b0) begin
            idle_bad++;
        end
        if (!rst && ready_o === 1'b0) ready_low++;
        if (rst) sym_idx = 0;
    end

    initial begin
        #400000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    // Convolution of the zero-padded bit stream with generators 111 and 101.
    function automatic sym_q_t model_frame(input bit_q_t bits);
        bit     ext[$];
        sym_q_t q;
        ext.push_back(1'b0);
        ext.push_back(1'b0);
        foreach (bits[i]) ext.push_back(bits[i]);
        ext.push_back(1'b0);
        ext.push_back(1'b0);
        for (int k = 2; k < ext.size(); k++)
            q.push_back({ext[k] ^ ext[k-1] ^ ext[k-2], ext[k] ^ ext[k-2]});
        return q;
    endfunction

    // Injected error expected on the idx-th symbol after reset.
    function automatic bit err_exp(input int idx);
`ifdef CONV_ENC_ERRINJ_EN
        return (idx < 256) && (((idx / 4) % (1 << (ERR_N - 2))) == 0);
`else
        return (idx < 0);
`endif
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic flush(input int n);
        en  = 1'b0;
        din = 1'($urandom);
        repeat (n) tick();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        en  = 1'($urandom);
        din = 1'($urandom);
        tick();
        tick();
        rst = 1'b0;
        en  = 1'b0;
    endtask

    // Drives one frame; gap_max > 0 inserts random idle cycles between bits.
    task automatic send_frame(input bit_q_t bits, input int gap_max);
        foreach (bits[i]) begin
            int gaps;
            int guard;
            gaps = (gap_max > 0 && i > 0) ? $urandom_range(gap_max, 0) : 0;
            repeat (gaps) begin
                en  = 1'b0;
                din = 1'($urandom);
                tick();
            end
            guard = 0;
            while (ready_o !== 1'b1 && guard < 10) begin
                en  = 1'($urandom);
                din = 1'($urandom);
                tick();
                guard++;
            end
            if (ready_o !== 1'b1) begin
                errors++;
                $display("FAIL ready_timeout got ready_o=%b want 1 within 10 cycles", ready_o);
            end
            en  = 1'b1;
            din = bits[i];
            tick();
            acc_cyc.push_back(cyc);
        end
        en  = 1'b0;
        din = 1'($urandom);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        en  = 1'b1;
        din = 1'b1;
        en1 = 1'b1;
        din1 = 1'b1;
        tick();
        tick();
        checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", valid_o); end
        checks++; if (d_out !== 2'b00) begin errors++; $display("FAIL reset_dout got %b want 00", d_out); end
        checks++; if (sof_o !== 1'b0 || eof_o !== 1'b0) begin errors++; $display("FAIL reset_sof_eof got %b%b want 00", sof_o, eof_o); end
        checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL reset_err got %b want 0", err_o); end
        checks++; if (ready_o !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", ready_o); end
        checks++; if (valid1 !== 1'b0 || ready1 !== 1'b1) begin errors++; $display("FAIL reset_dut1 got valid=%b ready=%b want 0 1", valid1, ready1); end
        rst = 1'b0;
        en  = 1'b0;
        en1 = 1'b0;
        tick();
    endtask

    task automatic test_frame_len_one();
        int idx1 = 0;
        for (int f = 0; f < 3; f++) begin
            bit_q_t b;
            sym_q_t e;
            b.push_back((f == 0) ? 1'b1 : 1'($urandom));
            e = model_frame(b);
            checks++; if (ready1 !== 1'b1) begin errors++; $display("FAIL len1_ready_idle got %b want 1", ready1); end
            en1  = 1'b1;
            din1 = b[0];
            tick();
            en1  = 1'($urandom);
            din1 = 1'($urandom);
            for (int j = 0; j < 3; j++) begin
                logic [1:0] ed;
                if (j > 0) tick();
                ed = e[j] ^ {err_exp(idx1), 1'b0};
                checks++;
                if (valid1 !== 1'b1 || dout1 !== ed || sof1 !== (j == 0) || eof1 !== (j == 2)
                    || err1 !== err_exp(idx1) || ready1 !== (j == 2)) begin
                    errors++;
                    $display("FAIL len1_f%0d_s%0d got v=%b d=%b sof=%b eof=%b err=%b rdy=%b want v=1 d=%b sof=%b eof=%b err=%b rdy=%b",
                             f, j, valid1, dout1, sof1, eof1, err1, ready1, ed, j == 0, j == 2, err_exp(idx1), j == 2);
                end
                idx1++;
            end
            en1 = 1'b0;
        end
        tick();
        checks++; if (valid1 !== 1'b0) begin errors++; $display("FAIL len1_idle got valid=%b want 0", valid1); end
    endtask

    task automatic test_encode();
        bit_q_t b;
        sym_q_t e;
        int base, rl0, n;
        b = '{1'b1, 1'b0, 1'b1, 1'b1};
        e = model_frame(b);
        flush(3);
        base = obs_sym.size();
        rl0 = ready_low;
        acc_cyc.delete();
        send_frame(b, 0);
        flush(4);
        n = obs_sym.size() - base;
        checks++; if (n != FL + 2) begin errors++; $display("FAIL encode_count got %0d want %0d", n, FL + 2); end
        checks++; if (ready_low - rl0 != 2) begin errors++; $display("FAIL encode_ready_low got %0d want 2", ready_low - rl0); end
        for (int i = 0; i < n && i < FL + 2; i++) begin
            int k;
            int ec;
            logic [1:0] ed;
            k  = base + i;
            ed = e[i] ^ {err_exp(obs_idx[k]), 1'b0};
            ec = (i < FL) ? acc_cyc[i] : acc_cyc[FL-1] + (i - FL + 1);
            checks++;
            if (obs_sym[k] !== ed || obs_sof[k] !== (i == 0) || obs_eof[k] !== (i == FL + 1)
                || obs_err[k] !== err_exp(obs_idx[k]) || obs_cyc[k] != ec) begin
                errors++;
                $display("FAIL encode_s%0d got d=%b sof=%b eof=%b err=%b cyc=%0d want d=%b sof=%b eof=%b err=%b cyc=%0d",
                         i, obs_sym[k], obs_sof[k], obs_eof[k], obs_err[k], obs_cyc[k],
                         ed, i == 0, i == FL + 1, err_exp(obs_idx[k]), ec);
            end
        end
    endtask

    task automatic test_gaps();
        bit_q_t b;
        sym_q_t e;
        int base, n;
        b = '{1'b1, 1'b0, 1'b1, 1'b1};
        e = model_frame(b);
        flush(3);
        base = obs_sym.size();
        acc_cyc.delete();
        for (int i = 0; i < FL; i++) begin
            if (i == 2) begin
                repeat (3) begin
                    en  = 1'b0;
                    din = 1'($urandom);
                    tick();
                    checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL gap_valid got %b want 0", valid_o); end
                end
            end
            en  = 1'b1;
            din = b[i];
            tick();
            acc_cyc.push_back(cyc);
        end
        flush(4);
        n = obs_sym.size() - base;
        checks++; if (n != FL + 2) begin errors++; $display("FAIL gap_count got %0d want %0d", n, FL + 2); end
        for (int i = 0; i < n && i < FL + 2; i++) begin
            int k;
            int ec;
            logic [1:0] ed;
            k  = base + i;
            ed = e[i] ^ {err_exp(obs_idx[k]), 1'b0};
            ec = (i < FL) ? acc_cyc[i] : acc_cyc[FL-1] + (i - FL + 1);
            checks++;
            if (obs_sym[k] !== ed || obs_sof[k] !== (i == 0) || obs_eof[k] !== (i == FL + 1) || obs_cyc[k] != ec) begin
                errors++;
                $display("FAIL gap_s%0d got d=%b sof=%b eof=%b cyc=%0d want d=%b sof=%b eof=%b cyc=%0d",
                         i, obs_sym[k], obs_sof[k], obs_eof[k], obs_cyc[k], ed, i == 0, i == FL + 1, ec);
            end
        end
    endtask

    task automatic test_back_to_back();
        bit_q_t b;
        sym_q_t e;
        int base, n;
        b = '{1'b1, 1'b1, 1'b1, 1'b1};
        e = model_frame(b);
        flush(3);
        base = obs_sym.size();
        send_frame(b, 0);
        send_frame(b, 0);
        flush(4);
        n = obs_sym.size() - base;
        checks++; if (n != 2 * (FL + 2)) begin errors++; $display("FAIL b2b_count got %0d want %0d", n, 2 * (FL + 2)); end
        for (int i = 0; i < n && i < 2 * (FL + 2); i++) begin
            int k;
            int j;
            logic [1:0] ed;
            k  = base + i;
            j  = i % (FL + 2);
            ed = e[j] ^ {err_exp(obs_idx[k]), 1'b0};
            checks++;
            if (obs_sym[k] !== ed || obs_sof[k] !== (j == 0) || obs_eof[k] !== (j == FL + 1)) begin
                errors++;
                $display("FAIL b2b_s%0d got d=%b sof=%b eof=%b want d=%b sof=%b eof=%b",
                         i, obs_sym[k], obs_sof[k], obs_eof[k], ed, j == 0, j == FL + 1);
            end
        end
        if (n >= 2 * (FL + 2)) begin
            checks++;
            if (obs_cyc[base + FL + 2] != obs_cyc[base + FL + 1] + 1) begin
                errors++;
                $display("FAIL b2b_sof_gap got sof at %0d eof at %0d want 1 cycle apart",
                         obs_cyc[base + FL + 2], obs_cyc[base + FL + 1]);
            end
        end
    endtask

    task automatic test_reset_mid();
        bit_q_t b;
        sym_q_t e;
        int base, n;
        flush(3);
        base = obs_sym.size();
        en  = 1'b1;
        din = 1'b1;
        tick();
        din = 1'b1;
        tick();
        rst = 1'b1;
        en  = 1'b1;
        din = 1'b1;
        tick();
        rst = 1'b0;
        en  = 1'b0;
        checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL rstmid_valid got %b want 0", valid_o); end
        checks++; if (ready_o !== 1'b1) begin errors++; $display("FAIL rstmid_ready got %b want 1", ready_o); end
        flush(4);
        n = obs_sym.size() - base;
        checks++; if (n != 2) begin errors++; $display("FAIL rstmid_no_tail got %0d symbols want 2", n); end
        if (n >= 2) begin
            checks++; if (obs_eof[base + 1] !== 1'b0) begin errors++; $display("FAIL rstmid_eof got %b want 0", obs_eof[base + 1]); end
        end
        for (int i = 0; i < FL; i++) b.push_back(1'($urandom));
        e = model_frame(b);
        base = obs_sym.size();
        send_frame(b, 0);
        flush(4);
        n = obs_sym.size() - base;
        checks++; if (n != FL + 2) begin errors++; $display("FAIL rstmid_new_count got %0d want %0d", n, FL + 2); end
        for (int i = 0; i < n && i < FL + 2; i++) begin
            int k;
            logic [1:0] ed;
            k  = base + i;
            ed = e[i] ^ {err_exp(obs_idx[k]), 1'b0};
            checks++;
            if (obs_sym[k] !== ed || obs_err[k] !== err_exp(obs_idx[k])) begin
                errors++;
                $display("FAIL rstmid_new_s%0d got d=%b err=%b want d=%b err=%b",
                         i, obs_sym[k], obs_err[k], ed, err_exp(obs_idx[k]));
            end
        end
    endtask

    task automatic test_random();
        localparam int NF = 8;
        sym_q_t e;
        int base, n;
        flush(3);
        base = obs_sym.size();
        acc_cyc.delete();
        for (int f = 0; f < NF; f++) begin
            bit_q_t b;
            sym_q_t m;
            for (int j = 0; j < FL; j++) b.push_back(1'($urandom));
            m = model_frame(b);
            foreach (m[x]) e.push_back(m[x]);
            send_frame(b, 3);
            repeat ($urandom_range(2, 0)) begin
                en  = 1'b0;
                din = 1'($urandom);
                tick();
            end
        end
        flush(4);
        n = obs_sym.size() - base;
        checks++; if (n != NF * (FL + 2)) begin errors++; $display("FAIL rand_count got %0d want %0d", n, NF * (FL + 2)); end
        for (int i = 0; i < n && i < NF * (FL + 2); i++) begin
            int k, j, f, ec;
            logic [1:0] ed;
            k  = base + i;
            j  = i % (FL + 2);
            f  = i / (FL + 2);
            ed = e[i] ^ {err_exp(obs_idx[k]), 1'b0};
            ec = (j < FL) ? acc_cyc[f*FL + j] : acc_cyc[f*FL + FL - 1] + (j - FL + 1);
            checks++;
            if (obs_sym[k] !== ed || obs_sof[k] !== (j == 0) || obs_eof[k] !== (j == FL + 1)
                || obs_err[k] !== err_exp(obs_idx[k]) || obs_cyc[k] != ec) begin
                errors++;
                $display("FAIL rand_s%0d got d=%b sof=%b eof=%b err=%b cyc=%0d want d=%b sof=%b eof=%b err=%b cyc=%0d",
                         i, obs_sym[k], obs_sof[k], obs_eof[k], obs_err[k], obs_cyc[k],
                         ed, j == 0, j == FL + 1, err_exp(obs_idx[k]), ec);
            end
        end
    endtask

    task automatic test_errinj();
        localparam int NF = 50;
        bit_q_t z;
        int base, n, nerr;
`ifdef CONV_ENC_ERRINJ_EN
        // Bursts at 0-3, 32-35, ..., 224-227 within the first 300 symbols.
        int exp_nerr = 32;
`else
        int exp_nerr = 0;
`endif
        for (int j = 0; j < FL; j++) z.push_back(1'b0);
        flush(3);
        do_reset();
        base = obs_sym.size();
        for (int f = 0; f < NF; f++) send_frame(z, 0);
        flush(4);
        n = obs_sym.size() - base;
        nerr = 0;
        checks++; if (n != NF * (FL + 2)) begin errors++; $display("FAIL inj_count got %0d want %0d", n, NF * (FL + 2)); end
        for (int i = 0; i < n; i++) begin
            int k;
            logic [1:0] ed;
            k  = base + i;
            ed = {err_exp(i), 1'b0};
            if (obs_err[k]) nerr++;
            checks++;
            if (obs_sym[k] !== ed || obs_err[k] !== err_exp(i)) begin
                errors++;
                $display("FAIL inj_s%0d got d=%b err=%b want d=%b err=%b", i, obs_sym[k], obs_err[k], ed, err_exp(i));
            end
        end
        checks++; if (nerr != exp_nerr) begin errors++; $display("FAIL inj_total got %0d want %0d", nerr, exp_nerr); end
    endtask

    task automatic test_idle_outputs();
        checks++;
        if (idle_bad != 0) begin
            errors++;
            $display("FAIL idle_outputs got %0d nonzero idle cycles want 0", idle_bad);
        end
    endtask

    initial begin
        test_reset();
        test_frame_len_one();
        test_encode();
        test_gaps();
        test_back_to_back();
        test_reset_mid();
        test_random();
        test_errinj();
        test_idle_outputs();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/conv_encoder_tx.md
CONV_ENCODER_TX -- requirements
Module: conv_encoder_tx

Interface
REQ-001 SHALL have parameter FRAME_LEN, default 64: data bits per frame, legal range 1..65535.
REQ-002 SHALL have parameter ERR_N, default 5: error-burst period exponent, legal range 3..8; used only under REQ-025.
REQ-003 SHALL have port clk, input, 1: sole clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-005 SHALL have port enable_i, input, 1: d_in valid this cycle.
REQ-006 SHALL have port d_in, input, 1: information bit.
REQ-007 SHALL have port ready_o, output, 1: block accepts d_in this cycle.
REQ-008 SHALL have port valid_o, output, 1: d_out holds a code symbol this cycle.
REQ-009 SHALL have port d_out, output, 2: code symbol; bit 1 is the G=7 (octal) output, bit 0 is the G=5 (octal) output.
REQ-010 SHALL have port sof_o, output, 1: high with the first symbol of a frame.
REQ-011 SHALL have port eof_o, output, 1: high with the last tail symbol of a frame.
REQ-012 SHALL have port err_o, output, 1: high when the current d_out has an injected error.

Function
REQ-013 SHALL implement a rate-1/2, K=3 convolutional code using shift register s[1:0], where s[0] is the previous input bit.
  - d_out[1] = d ^ s[0] ^ s[1]
  - d_out[0] = d ^ s[1]
  - after each encoded bit: s <= {s[0], d}
REQ-014 SHALL use an FSM with states IDLE, DATA, TAIL; reset state is IDLE.
REQ-015 SHALL drive ready_o = 1 in IDLE and DATA, and ready_o = 0 in TAIL.
REQ-016 A bit SHALL be accepted when enable_i && ready_o; its symbol appears on d_out/valid_o exactly 1 cycle later, with outputs registered.
REQ-017 SHALL transition IDLE -> DATA on the first accepted bit; that bit's symbol carries sof_o = 1.
REQ-018 SHALL keep a data-bit counter, 16 bits wide, counting accepted bits in the frame.
  - After the FRAME_LEN-th accepted bit: go to TAIL.
  - If FRAME_LEN = 1: go IDLE -> TAIL directly.
REQ-019 In DATA, a cycle with enable_i = 0 SHALL produce valid_o = 0 next cycle, with s and the counter held; gaps are unlimited.
REQ-020 TAIL SHALL encode 2 zero bits on 2 consecutive cycles, ignoring enable_i and d_in.
  - Both symbols carry valid_o = 1.
  - The second symbol carries eof_o = 1.
  - Then: s = 00, counter = 0, state = IDLE.
REQ-021 SHALL allow back-to-back frames: IDLE accepts a new bit in the cycle after the last tail bit is encoded, with no dead cycle beyond the ready_o = 0 TAIL cycles.
REQ-022 When valid_o = 0, d_out, sof_o, eof_o and err_o SHALL be 0.

Reset
REQ-023 When rst = 1 at a rising clk edge, the block SHALL set:
  - state = IDLE, s = 00, data counter = 0, symbol counter = 0
  - valid_o = 0, d_out = 00, sof_o = 0, eof_o = 0, err_o = 0
  - ready_o = 1 from the following cycle
REQ-024 Reset mid-frame (DATA or TAIL) SHALL abandon the frame with no tail and no eof_o; any bit presented in the reset cycle is discarded.

Configuration
REQ-025 With macro CONV_ENC_ERRINJ_EN defined, the block SHALL inject channel errors.
  - A 9-bit saturating symbol counter (saturates at 256) increments per valid_o symbol since reset.
  - When counter < 256 and counter[ERR_N-1:2] == 0, the emitted d_out[1] is inverted and err_o = 1.
  - d_out[0] is never corrupted.
REQ-026 Without CONV_ENC_ERRINJ_EN, the block SHALL have no counter logic, err_o = 0 constantly, and d_out exactly per REQ-013.

Verification
REQ-027 SHALL verify encoding: FRAME_LEN = 4, enable_i held 1, d_in = 1,0,1,1 -> d_out = 11,10,00,01 (data), 01,11 (tail); sof_o on the first symbol, eof_o on the 6th; ready_o = 0 for 2 cycles.
REQ-028 SHALL verify gaps: same frame with enable_i = 0 for 3 cycles between bits 2 and 3 -> identical symbol sequence, valid_o = 0 during the gap.
REQ-029 SHALL verify back-to-back frames: two FRAME_LEN = 4 frames of all-ones -> each frame gives 11,01,10,10,01,11; the second sof_o comes 1 cycle after the first eof_o.
REQ-030 SHALL verify reset mid-frame: rst after 2 data bits -> next cycle valid_o = 0, ready_o = 1; a new frame encodes from s = 00.
REQ-031 SHALL verify injection with the macro on, ERR_N = 5, all-zero input: symbols 0-3 and 32-35 emit d_out = 10 with err_o = 1; all others emit 00; no errors from symbol 256 onward.
REQ-032 SHALL verify the macro off: same stimulus as REQ-031 -> all symbols 00, err_o never asserted.
